// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, line levels and frame-length helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  function automatic int frame_bits(input int data_w, input int stop_bits, input int parity);
    return 1 + data_w + parity + stop_bits;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter emitting a one-cycle tick on the last clk of each bit
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frames and serialises a byte for the TX output mux; parity via UART_TX_PARITY_EN
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_dff,
  output logic              sel,
  output logic              busy,
  output logic              tx_done
);
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam int P = 0;
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  localparam int FW = frame_bits(DATA_W, STOP_BITS, P);
  localparam int BW = $clog2(DATA_W + 1);
  tx_state_t state, state_n;
  logic [FW-1:0] shreg, frame;
  logic [BW-1:0] bit_cnt;
  logic tick, accept, last_data, last_stop;
  assign accept    = state == IDLE && tx_start;
  assign last_data = bit_cnt == BW'(DATA_W - 1);
  assign last_stop = bit_cnt == BW'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  assign frame = {{STOP_BITS{LINE_IDLE}}, ^data_in, data_in, START_BIT};
`else
  assign frame = {{STOP_BITS{LINE_IDLE}}, data_in, START_BIT};
`endif
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state != IDLE),
    .tick  (tick)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = tx_start ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = tick && last_data ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
      PARITY:  state_n = tick ? STOP : PARITY;
`endif
      STOP:    state_n = tick && last_stop ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // bit_cnt restarts on every state change so it indexes data bits, then stop bits
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '1;
    end else begin
      state <= state_n;
      if (accept) begin
        shreg   <= frame;
        bit_cnt <= '0;
      end else if (tick) begin
        shreg   <= {LINE_IDLE, shreg[FW-1:1]};
        bit_cnt <= state_n != state ? '0 : bit_cnt + BW'(1);
      end
    end
  end
  assign out_dff = shreg[0];
  assign sel     = state == IDLE;
  assign busy    = state != IDLE;
  assign tx_done = state == STOP && tick && last_stop;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: table-driven and randomized checks of uart_tx_ctrl against a line-level model
module tb_uart_tx_ctrl;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FB   = 1 + 8 + P + 1;
  localparam int FLEN = FB * CPB;
  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;
  logic clk = 0, reset, tx_start;
  logic [7:0] data_in;
  logic out_dff, sel, busy, tx_done;
  int passed = 0, total = 0;
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .data_in  (data_in),
    .out_dff  (out_dff),
    .sel      (sel),
    .busy     (busy),
    .tx_done  (tx_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (P == 1 && i == 9) return ^d;
    return 1'b1;
  endfunction
  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1;
    data_in  = d;
    @(negedge clk);
    tx_start = 0;
    data_in  = ~d;
  endtask
  // entered on the first negedge after acceptance; returns on the idle gap negedge
  task automatic check_frame(input logic [7:0] d, input logic exp_par, input int poke_at, input string nm);
    int bad = 0;
    logic [FB-1:0] rx = '0;
    for (int k = 1; k <= FLEN; k++) begin
      if (sel !== 1'b0 || busy !== 1'b1 || out_dff !== exp_bit(d, (k - 1) / CPB) || tx_done !== (k == FLEN)) bad++;
      if (k % CPB == CPB / 2) rx[(k-1)/CPB] = out_dff;
      if (poke_at > 0 && k == poke_at) begin
        tx_start = 1;
        data_in  = 8'h81;
      end else if (poke_at > 0 && k == poke_at + 1) tx_start = 0;
      @(negedge clk);
    end
    check({nm, "_wave_bad_cycles"}, bad, 0);
    check({nm, "_rx_start"}, rx[0], 1'b0);
    check({nm, "_rx_data"}, rx[8:1], d);
    check({nm, "_rx_stop"}, rx[FB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
    check({nm, "_rx_parity"}, rx[9], exp_par);
`endif
    check({nm, "_idle_after"}, {out_dff, sel, busy, tx_done}, 4'b1100);
  endtask
  initial begin
    vec_t vecs[6];
    int bad, dn;
    logic [7:0] d;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h3C, 1'b0};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h01, 1'b1};
    reset = 1;
    tx_start = 0;
    data_in = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {out_dff, sel, busy, tx_done}, 4'b1100);
    reset = 0;
    bad = 0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if ({out_dff, sel, busy} !== 3'b110) bad++;
      if (tx_done === 1'b1) dn++;
    end
    check("idle_line_bad_cycles", bad, 0);
    check("idle_tx_done_pulses", dn, 0);
    foreach (vecs[i]) begin
      start_frame(vecs[i].data);
      check_frame(vecs[i].data, vecs[i].exp_par, 0, "table");
    end
    start_frame(8'h3C);
    check_frame(8'h3C, 1'b0, 10, "ignore_start");
    bad = 0;
    repeat (6) begin
      if (sel !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("ignore_no_second_frame", bad, 0);
    @(negedge clk);
    tx_start = 1;
    data_in  = 8'h00;
    @(negedge clk);
    data_in  = 8'hFF;
    check_frame(8'h00, 1'b0, 0, "b2b_first");
    @(negedge clk);
    tx_start = 0;
    check_frame(8'hFF, 1'b0, 0, "b2b_second");
    start_frame(8'hC3);
    repeat (16) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midframe_reset_idle", {out_dff, sel, busy, tx_done}, 4'b1100);
    start_frame(8'h5A);
    check_frame(8'h5A, 1'b0, 0, "after_reset");
    repeat (6) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame(d);
      check_frame(d, ^d, 0, "random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
